// File: rtl/tama_pkg.sv
`default_nettype none
// ==========================================================================
// tama_pkg - action/stat indices, arbiter state encoding, decay defaults
// Revision: 1.0
// ==========================================================================
package tama_pkg;

    localparam int NUM_ACT    = 4;

    localparam int ACT_FEED   = 0;
    localparam int ACT_SLEEP  = 1;
    localparam int ACT_PLAY   = 2;
    localparam int ACT_HEAL   = 3;

    localparam int STAT_FOOD  = 0;
    localparam int STAT_SLEEP = 1;
    localparam int STAT_FUN   = 2;
    localparam int STAT_HAPPY = 3;

    localparam int DEF_DECAY_FOOD  = 30;
    localparam int DEF_DECAY_SLEEP = 31;
    localparam int DEF_DECAY_FUN   = 23;
    localparam int DEF_DECAY_HAPPY = 24;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'b00,
        ARB_GRANT    = 2'b01,
        ARB_COOLDOWN = 2'b10
    } arb_state_e;

    // The reset pointer value 3 behaves like 2, so feed is the first candidate.
    function automatic logic [1:0] rr_start(input logic [1:0] rr_ptr);
        case (rr_ptr)
            2'd0:    rr_start = 2'd1;
            2'd1:    rr_start = 2'd2;
            default: rr_start = 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] rr_pick(input logic [3:0] pend, input logic [1:0] start);
        logic [1:0] o1;
        logic [1:0] o2;
        o1 = (start == 2'd2) ? 2'd0 : start + 2'd1;
        o2 = (o1 == 2'd2) ? 2'd0 : o1 + 2'd1;
        if (pend[start])
            rr_pick = start;
        else if (pend[o1])
            rr_pick = o1;
        else
            rr_pick = o2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tama_decay_timer.sv
`default_nettype none
// ==========================================================================
// tama_decay_timer - per-stat seconds down-counter emitting a decay pulse
// Revision: 1.0
// ==========================================================================
module tama_decay_timer #(
    parameter int PERIOD = 30
) (
    input  logic clk,
    input  logic rst,
    input  logic sec_tick,
    input  logic reload,
    input  logic enable,
    output logic pulse
);

    localparam logic [6:0] PERIOD_L = 7'(PERIOD);

    logic [6:0] cnt_q;
    logic [6:0] cnt_d;

    // A reload wins over a coinciding expiry, which swallows that pulse.
    always_comb begin
        cnt_d = cnt_q;
        pulse = 1'b0;
        if (reload) begin
            cnt_d = PERIOD_L;
        end else if (enable && sec_tick) begin
            if (cnt_q == 7'd1) begin
                pulse = 1'b1;
                cnt_d = PERIOD_L;
            end else begin
                cnt_d = cnt_q - 7'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            cnt_q <= PERIOD_L;
        else
            cnt_q <= cnt_d;
    end

endmodule
`default_nettype wire

// File: rtl/tama_action_sched.sv
`default_nettype none
// ==========================================================================
// tama_action_sched - action arbiter, grant cooldown, 1 s tick, stat decay
// Revision: 1.0
// ==========================================================================
module tama_action_sched
    import tama_pkg::*;
#(
    parameter int TICK_DIV    = 50000000,
    parameter int COOLDOWN_S  = 3,
    parameter int DECAY_FOOD  = DEF_DECAY_FOOD,
    parameter int DECAY_SLEEP = DEF_DECAY_SLEEP,
    parameter int DECAY_FUN   = DEF_DECAY_FUN,
    parameter int DECAY_HAPPY = DEF_DECAY_HAPPY
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       dead,
    input  logic       test_mode,
    output logic [3:0] grant,
    output logic       busy,
    output logic [3:0] decay,
    output logic       sec_tick
);

    localparam int               PSC_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(TICK_DIV - 1);
    localparam logic [3:0]       CD_LOAD  = 4'(COOLDOWN_S);

    logic [PSC_W-1:0] psc_q;
    logic [3:0]       req_d_q;
    logic [3:0]       pending_q, pending_d;
    arb_state_e       state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       rr_q, rr_d;
    logic [3:0]       cd_q, cd_d;

    logic [3:0] rise;
    logic [3:0] clr;
    logic [3:0] sel_oh;
    logic [1:0] pick;
    logic [3:0] reload_w;
    logic [3:0] pulse_w;

    assign sec_tick = (psc_q == PSC_LAST);
    assign rise     = req & ~req_d_q;
    assign sel_oh   = 4'b0001 << sel_q;
    assign pick     = pending_q[ACT_HEAL] ? 2'(ACT_HEAL) : rr_pick(pending_q, rr_start(rr_q));
    assign grant    = (state_q == ARB_GRANT && !dead) ? sel_oh : 4'b0000;
    assign busy     = (state_q != ARB_IDLE);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        rr_d    = rr_q;
        cd_d    = cd_q;
        clr     = 4'b0000;
        if (dead) begin
            state_d = ARB_IDLE;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (pending_q != 4'b0000) begin
                        sel_d   = pick;
                        state_d = ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    clr = sel_oh;
                    if (sel_q != 2'(ACT_HEAL))
                        rr_d = sel_q;
                    cd_d    = CD_LOAD;
                    state_d = ARB_COOLDOWN;
                end
                ARB_COOLDOWN: begin
                    if (cd_q == 4'd0)
                        state_d = ARB_IDLE;
                    else if (sec_tick)
                        cd_d = cd_q - 4'd1;
                end
                default: state_d = ARB_IDLE;
            endcase
        end
        // A fresh edge on the granted requester in the grant cycle stays latched.
        pending_d = dead ? 4'b0000 : ((pending_q & ~clr) | rise);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            psc_q     <= '0;
            req_d_q   <= 4'b0000;
            pending_q <= 4'b0000;
            state_q   <= ARB_IDLE;
            sel_q     <= 2'd0;
            rr_q      <= 2'd3;
            cd_q      <= 4'd0;
        end else begin
            psc_q     <= sec_tick ? '0 : psc_q + PSC_W'(1);
            req_d_q   <= req;
            pending_q <= pending_d;
            state_q   <= state_d;
            sel_q     <= sel_d;
            rr_q      <= rr_d;
            cd_q      <= cd_d;
        end
    end

    // Heal never restarts a decay period; the happy timer has no grant reload.
    assign reload_w = {1'b0, grant[ACT_PLAY:ACT_FEED]};

    for (genvar i = 0; i < NUM_ACT; i++) begin : g_decay
        tama_decay_timer #(
            .PERIOD((i == STAT_FOOD)  ? DECAY_FOOD  :
                    (i == STAT_SLEEP) ? DECAY_SLEEP :
                    (i == STAT_FUN)   ? DECAY_FUN   : DECAY_HAPPY)
        ) u_timer (
            .clk      (clk),
            .rst      (rst),
            .sec_tick (sec_tick),
            .reload   (reload_w[i]),
            .enable   (!dead),
            .pulse    (pulse_w[i])
        );
    end

    assign decay = (test_mode || dead) ? 4'b0000 : pulse_w;

endmodule
`default_nettype wire
